// File: rtl/servo_pkg.sv
// Shared servo definitions: default frame timing, tick width, command FSM states
// and the 8-bit position-to-width map used by the single-channel controllers.
package servo_pkg;

  localparam int DEF_PERIOD    = 1_000_000;
  localparam int DEF_WIDTH_MIN = 28204;
  localparam int DEF_WIDTH_MAX = 76115;

  localparam int TICK_W = $clog2(DEF_PERIOD);
  typedef logic [TICK_W-1:0] tick_t;

  typedef enum logic {
    HS_IDLE    = 1'b0,
    HS_COMPUTE = 1'b1
  } hs_state_t;

  localparam int MAP_SPAN = DEF_WIDTH_MAX - DEF_WIDTH_MIN;
  localparam int MAP_W    = $clog2(MAP_SPAN + 1) + 8;

  // Full-width product before the shift so the low position bits are not lost.
  function automatic tick_t pos_to_width(input logic [7:0] pos);
    logic [MAP_W-1:0] prod;
    prod = MAP_W'(MAP_SPAN) * MAP_W'(pos);
    return tick_t'(DEF_WIDTH_MIN) + tick_t'(prod >> 8);
  endfunction

endpackage

// File: rtl/servo_pwm_multi_channel.sv
// One servo output: target/current width registers, optional per-frame ramp,
// pwm compare against the shared frame counter and busy flag. SERVO_RAMP_EN enables the ramp.
module servo_channel
  import servo_pkg::*;
#(
  parameter int CNT_W     = TICK_W,
`ifdef SERVO_RAMP_EN
  parameter int STEP      = 500,
`endif
  parameter int WIDTH_MIN = DEF_WIDTH_MIN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_end,
  input  logic [CNT_W-1:0] cnt,
  input  logic             tgt_we,
  input  logic [CNT_W-1:0] tgt_width,
  output logic             pwm,
  output logic             busy
);

  logic [CNT_W-1:0] cur;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] ramp_w;
  logic [CNT_W-1:0] cur_nx;
  logic [CNT_W-1:0] tgt_nx;

`ifdef SERVO_RAMP_EN
  localparam logic [CNT_W-1:0] STEP_W = CNT_W'(STEP);

  always_comb begin
    ramp_w = target;
    if ((target > cur) && ((target - cur) > STEP_W)) begin
      ramp_w = cur + STEP_W;
    end else if ((cur > target) && ((cur - target) > STEP_W)) begin
      ramp_w = cur - STEP_W;
    end
  end
`else
  assign ramp_w = target;
`endif

  // cur only moves on the boundary edge, and sees the pre-write target there.
  assign cur_nx = frame_end ? ramp_w : cur;
  assign tgt_nx = tgt_we ? tgt_width : target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur    <= CNT_W'(WIDTH_MIN);
      target <= CNT_W'(WIDTH_MIN);
      pwm    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      cur    <= cur_nx;
      target <= tgt_nx;
      busy   <= (cur_nx != tgt_nx);
      pwm    <= (cnt < cur);
    end
  end

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: shared frame counter, command handshake and position
// mapping feeding CHANNELS servo_channel instances. Ramp limiting via SERVO_RAMP_EN.
//
// state      | meaning
// HS_IDLE    | cmd_ready high, waiting for cmd_valid
// HS_COMPUTE | command latched, mapped width written to its channel target
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int POS_W     = 8,
  parameter int PERIOD    = DEF_PERIOD,
  parameter int WIDTH_MIN = DEF_WIDTH_MIN,
  parameter int WIDTH_MAX = DEF_WIDTH_MAX,
  parameter int STEP      = 500,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CH_W-1:0]     cmd_channel,
  input  logic [POS_W-1:0]    cmd_position,
  output logic [CHANNELS-1:0] pwm,
  output logic [CHANNELS-1:0] busy,
  output logic                frame_start
);

  localparam int CNT_W = $clog2(PERIOD);
  localparam int SPAN  = WIDTH_MAX - WIDTH_MIN;
  localparam int MUL_W = $clog2(SPAN + 1) + POS_W;

  if ((STEP < 1) || (WIDTH_MAX <= WIDTH_MIN) || (WIDTH_MAX > PERIOD) ||
      (CHANNELS < 1) || (CHANNELS > 8)) begin : g_bad_cfg
    $error("servo_pwm_multi: inconsistent parameter set");
  end

  logic [CNT_W-1:0] cnt;
  logic             frame_end;

  assign frame_end = (cnt == CNT_W'(PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= frame_end ? '0 : cnt + CNT_W'(1);
      frame_start <= frame_end;
    end
  end

  hs_state_t        hs_state;
  logic [CH_W-1:0]  ch_q;
  logic [POS_W-1:0] pos_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_state  <= HS_IDLE;
      cmd_ready <= 1'b1;
      ch_q      <= '0;
      pos_q     <= '0;
    end else begin
      case (hs_state)
        HS_IDLE: begin
          if (cmd_valid) begin
            hs_state  <= HS_COMPUTE;
            cmd_ready <= 1'b0;
            ch_q      <= cmd_channel;
            pos_q     <= cmd_position;
          end
        end
        HS_COMPUTE: begin
          hs_state  <= HS_IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          hs_state  <= HS_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  logic [MUL_W-1:0] product;
  logic [CNT_W-1:0] tgt_width;
  logic             tgt_wr;

  assign product   = MUL_W'(SPAN) * MUL_W'(pos_q);
  assign tgt_width = CNT_W'(WIDTH_MIN) + CNT_W'(product >> POS_W);
  assign tgt_wr    = (hs_state == HS_COMPUTE);

  // Out-of-range channel indices match no instance, so such commands are dropped.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    servo_channel #(
      .CNT_W     (CNT_W),
`ifdef SERVO_RAMP_EN
      .STEP      (STEP),
`endif
      .WIDTH_MIN (WIDTH_MIN)
    ) u_channel (
      .clk       (clk),
      .rst_n     (rst_n),
      .frame_end (frame_end),
      .cnt       (cnt),
      .tgt_we    (tgt_wr && (ch_q == CH_W'(g))),
      .tgt_width (tgt_width),
      .pwm       (pwm[g]),
      .busy      (busy[g])
    );
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Frame-level bench for servo_pwm_multi on a shortened frame; expected widths are
// queued from a per-frame model and compared against measured pulse lengths.
module tb_servo_pwm_multi;

  localparam int CH     = 3;
  localparam int CH_W   = 2;
  localparam int POS_W  = 8;
  localparam int PERIOD = 200;
  localparam int WMIN   = 20;
  localparam int WMAX   = 150;
  localparam int STEP   = 7;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [CH_W-1:0]  cmd_channel = '0;
  logic [POS_W-1:0] cmd_position = '0;
  logic [CH-1:0]    pwm;
  logic [CH-1:0]    busy;
  logic             frame_start;

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .CHANNELS  (CH),
    .POS_W     (POS_W),
    .PERIOD    (PERIOD),
    .WIDTH_MIN (WMIN),
    .WIDTH_MAX (WMAX),
    .STEP      (STEP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_channel  (cmd_channel),
    .cmd_position (cmd_position),
    .pwm          (pwm),
    .busy         (busy),
    .frame_start  (frame_start)
  );

  int total = 0;
  int bad   = 0;

  int mcur[CH];
  int mtgt[CH];
  int late_ch = -1;
  int late_w  = 0;
  int exp_q[$];

  typedef struct {
    int off;
    int ch;
    int pos;
  } cmd_t;
  cmd_t sched[$];

  function automatic int map_pos(input int pos);
    return WMIN + ((WMAX - WMIN) * pos) / (1 << POS_W);
  endfunction

  function automatic int ramp(input int c, input int t);
`ifdef SERVO_RAMP_EN
    if (t > c) return (t - c > STEP) ? c + STEP : t;
    if (c > t) return (c - t > STEP) ? c - STEP : t;
    return c;
`else
    return t;
`endif
  endfunction

  function automatic int busy_model();
    int v = 0;
    for (int c = 0; c < CH; c++) if (mcur[c] != mtgt[c]) v |= (1 << c);
    return v;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      mcur[c] = WMIN;
      mtgt[c] = WMIN;
    end
    late_ch = -1;
  endtask

  task automatic model_boundary();
    for (int c = 0; c < CH; c++) mcur[c] = ramp(mcur[c], mtgt[c]);
    if (late_ch >= 0) mtgt[late_ch] = late_w;
    late_ch = -1;
  endtask

  // Runs one whole frame starting at frame_start; commands from sched are issued
  // at their cycle offsets. rst_at >= 0 aborts the frame with a reset pulse.
  task automatic run_frame(input string tag, input int rst_at = -1);
    int  hi[CH];
    bit  seen = 1'b0;
    for (int c = 0; c < CH; c++) hi[c] = 0;
    for (int k = 0; k < PERIOD + 4 && !seen; k++) begin
      @(negedge clk);
      seen = frame_start;
    end
    if (!seen) begin
      check({tag, " frame_start timeout"}, int'(frame_start), 1);
      sched.delete();
      return;
    end
    model_boundary();
    for (int c = 0; c < CH; c++) exp_q.push_back(mcur[c]);
    check({tag, " busy@start"}, int'(busy), busy_model());
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) @(negedge clk);
      for (int c = 0; c < CH; c++) if (pwm[c]) hi[c]++;
      if (i == 1) check({tag, " frame_start one cycle"}, int'(frame_start), 0);
      if (i == PERIOD - 1) check({tag, " busy@end"}, int'(busy), busy_model());
      if (i == rst_at) begin
        check({tag, " pwm0 before reset"}, int'(pwm[0]), (rst_at - 1 < mcur[0]) ? 1 : 0);
        check({tag, " busy0 before reset"}, int'(busy[0]), (mcur[0] != mtgt[0]) ? 1 : 0);
        #2 rst_n = 1'b0;
        #1;
        check({tag, " pwm in reset"}, int'(pwm), 0);
        check({tag, " busy in reset"}, int'(busy), 0);
        check({tag, " cmd_ready in reset"}, int'(cmd_ready), 1);
        check({tag, " frame_start in reset"}, int'(frame_start), 0);
        model_reset();
        for (int c = 0; c < CH; c++) void'(exp_q.pop_front());
        sched.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      foreach (sched[k]) begin
        if (i == sched[k].off) begin
          check($sformatf("%s ready before cmd%0d", tag, k), int'(cmd_ready), 1);
          cmd_valid    = 1'b1;
          cmd_channel  = CH_W'(sched[k].ch);
          cmd_position = POS_W'(sched[k].pos);
        end else if (i == sched[k].off + 1) begin
          cmd_valid = 1'b0;
          check($sformatf("%s ready low after cmd%0d", tag, k), int'(cmd_ready), 0);
          if (sched[k].ch < CH) begin
            if (i == PERIOD - 1) begin
              late_ch = sched[k].ch;
              late_w  = map_pos(sched[k].pos);
            end else begin
              mtgt[sched[k].ch] = map_pos(sched[k].pos);
            end
          end
        end
      end
    end
    for (int c = 0; c < CH; c++)
      check($sformatf("%s width ch%0d", tag, c), hi[c], exp_q.pop_front());
    sched.delete();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("reset pwm", int'(pwm), 0);
    check("reset busy", int'(busy), 0);
    check("reset frame_start", int'(frame_start), 0);
    check("reset cmd_ready", int'(cmd_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("first pulse after release", int'(pwm), 7);
    check("no frame_start after release", int'(frame_start), 0);

    run_frame("idle");

    sched.push_back('{off: 5, ch: 0, pos: 128});
    run_frame("cmd ch0 128");
    run_frame("ch0 applied");

    sched.push_back('{off: 5, ch: 0, pos: 0});
    sched.push_back('{off: 7, ch: 0, pos: 255});
    sched.push_back('{off: 20, ch: 1, pos: 255});
    run_frame("back to back");
    run_frame("after b2b");

    sched.push_back('{off: 10, ch: CH, pos: 200});
    sched.push_back('{off: PERIOD - 2, ch: 2, pos: 128});
    run_frame("bad ch + late cmd");
    run_frame("late +1");
    run_frame("late +2");

    for (int f = 0; f < 20; f++) run_frame($sformatf("settle %0d", f));

    sched.push_back('{off: 3, ch: 0, pos: 0});
    run_frame("reset mid pulse", 10);
    run_frame("post reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/servo_pwm_multi.md
# servo_pwm_multi

Multi-channel, parametrised successor to the single-servo two-position controller: drives CHANNELS hobby-servo PWM outputs from one shared 20 ms frame counter, each channel commanded to an arbitrary POS_W-bit position instead of a 1-bit choice. Positions map linearly onto [WIDTH_MIN, WIDTH_MAX) pulse widths. Optional slew limiting ramps pulse width toward the target at most STEP ticks per frame, so cube-face turns do not jerk the gripper servos. Sits between the move sequencer and the servo pins.

## Interface
- CHANNELS, 2, number of servo outputs (1..8)
- POS_W, 8, position command width
- PERIOD, 1000000, frame length in clock ticks (20 ms at 50 MHz)
- WIDTH_MIN, 28204, pulse width (ticks) for position 0
- WIDTH_MAX, 76115, pulse width span end (position 2^POS_W maps here, exclusive)
- STEP, 500, max width change per frame when ramping (ticks, >=1)
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  block can accept a command this cycle
- cmd_channel  in  clog2(CHANNELS) (min 1)  target channel
- cmd_position  in  POS_W  requested position
- pwm  out  CHANNELS  servo control outputs
- busy  out  CHANNELS  channel current width differs from its target
- frame_start  out  1  one-cycle pulse when counter wraps to 0

## Operation
- Frame counter cnt runs 0..PERIOD-1, wraps to 0; shared by all channels.
- Handshake: command accepted on clock edge with cmd_valid && cmd_ready. Next cycle is the compute cycle: target[ch] <= WIDTH_MIN + (((WIDTH_MAX-WIDTH_MIN) * cmd_position) >> POS_W); cmd_ready is low during that cycle, high otherwise.
- cmd_channel >= CHANNELS: command accepted (handshake completes), no state changes.
- Multiplier width: clog2(WIDTH_MAX-WIDTH_MIN)+POS_W bits, unsigned, no truncation before the shift.
- cur[ch] (active pulse width) updates only on the cycle cnt == PERIOD-1, so every emitted pulse is whole and glitch-free; a new target mid-frame never alters the current pulse.
- pwm[ch] registered: high when cnt < cur[ch].
- busy[ch] = (cur[ch] != target[ch]), registered alongside cur.
- Back-to-back commands to the same channel within one frame: last computed target wins at the frame boundary.
- Target written in the same cycle as cnt == PERIOD-1: cur update uses the old target; new target applies at the following boundary.

## Timing
- Reset (async assert, sync deassert assumed from board): cnt=0, cur[]=target[]=WIDTH_MIN, pwm=0, busy=0, frame_start=0, cmd_ready=1.
- pwm lags cnt by one cycle; first pulse after reset starts the cycle after release; frame_start asserts the cycle cnt is 0 (one cycle before pwm rises).
- Command-to-target latency: 2 edges (accept, compute). Target-to-pulse latency: up to one frame plus 1 cycle.
- Max command rate: one per 2 cycles.
- Reset mid-ramp or mid-command: all in-flight state discarded, values as above.

## Configuration
- SERVO_RAMP_EN defined: at each frame boundary cur moves toward target by min(STEP, |target-cur|); busy stays high for ceil(|delta|/STEP) frames.
- SERVO_RAMP_EN undefined: cur <= target at each boundary (one-frame jump); STEP unused; busy high at most until the next boundary.

## Structure
- Package servo_pkg: default PERIOD/WIDTH_MIN/WIDTH_MAX constants, frame-tick type width, position-to-width function shared with the single-channel controllers.
- One sub-module servo_channel (per-channel target/cur registers, ramp step, pwm compare, busy), generated CHANNELS times; top holds counter, handshake and mapping multiplier.

## Test plan
- Reset release, no commands -> every pwm high exactly 28204 cycles per 1000000-cycle frame, busy=0.
- Command ch0 pos 128, ramp off -> target 52159; next full frame ch0 high 52159 cycles, ch1 unchanged at 28204.
- Command ch1 pos 255, ramp on, STEP 500 -> widths 28704, 29204, ... reaching 75927 after 96 frames; busy drops the frame cur hits 75927.
- Two commands ch0 pos 0 then pos 255 in same frame -> cmd_ready low cycle after each accept; next frame uses 75927 (ramp off).
- Command landing on cnt == PERIOD-1 -> applied one frame later; cmd_channel = CHANNELS -> handshake completes, all outputs unchanged.
- Assert reset mid-pulse during ramp -> pwm and busy go 0 immediately; after release widths back to 28204.
